uart_tx_arb: RTL and testbench
==============================

# uart_tx_arb

Round-robin arbiter that shares one multi-byte UART transmit path among several requesters. Each requester presents a fixed-length frame; the arbiter grants one at a time, launches it into the downstream multi-byte sender with a one-cycle request pulse, and waits for its frame-done strobe. It then enforces an inter-frame gap and moves on. It sits between application logic (status reporters, debug taps, command responders) and the multi-byte UART sender.

## Interface
Parameters:
- `CH_NUM`, 4: number of requester channels, 2..8.
- `FRAME_BYTES`, 3: bytes per frame; must equal the downstream sender's byte count.
- `GAP_CYC`, 16: idle sys_clk cycles between frames, 0..65535.
- `WDT_CYC`, 2000000: watchdog limit in cycles. Used only when `UART_ARB_WDT_EN` is defined.

Ports:
- `sys_clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low; sampled on the rising edge of `sys_clk`.
- `ch_req`  in  CH_NUM  per-channel frame request; level, held until `ch_gnt`.
- `ch_dat`  in  CH_NUM*FRAME_BYTES*8  frames. Channel k occupies bits [k*FRAME_BYTES*8 +: FRAME_BYTES*8], LSB byte sent first.
- `ch_gnt`  out  CH_NUM  one-cycle pulse: channel's frame captured; requester may drop `ch_req` or change data.
- `ch_done`  out  CH_NUM  one-cycle pulse: channel's frame fully transmitted.
- `ch_err`  out  CH_NUM  one-cycle pulse: watchdog abort. Tied to 0 without the macro.
- `tx_req`  out  1  one-cycle launch pulse to the sender.
- `tx_dat`  out  FRAME_BYTES*8  captured frame to the sender; stable from launch until frame end.
- `tx_done`  in  1  one-cycle frame-complete strobe from the sender.
- `busy`  out  1  high in any state except IDLE.
- `cur_ch`  out  3  index of the channel currently or last granted.

## Operation
- State machine: IDLE, SEND, WAIT, GAP.
- **IDLE:**
  - If `ch_req` is nonzero, the round-robin search starts at `rr_ptr` and picks the first set bit k, wrapping modulo CH_NUM.
  - Next state is SEND.
  - Registered on the same edge: `tx_dat` = frame k, `cur_ch` = k, `ch_gnt[k]` = 1, `rr_ptr` = (k+1) mod CH_NUM.
- **SEND:** `tx_req` = 1 for exactly this cycle; next state is WAIT.
- **WAIT:**
  - On `tx_done` = 1: `ch_done[cur_ch]` pulses next cycle; next state is GAP, or IDLE if GAP_CYC = 0.
  - With the macro: if the WAIT cycle counter reaches WDT_CYC-1 without `tx_done`, `ch_err[cur_ch]` pulses and the next state is GAP (or IDLE if GAP_CYC = 0).
- **GAP:**
  - A 16-bit counter counts GAP_CYC cycles, then returns to IDLE.
  - The counter clears on GAP entry.
- `tx_done` outside WAIT is ignored. It must not produce `ch_done` or change state.
- Fairness: a channel that is continuously requesting is granted at most once per CH_NUM frames while other channels are requesting.
- A requester that drops `ch_req` before grant is simply skipped; no error is raised.
- `ch_dat` is sampled only on the grant edge.

## Timing
- Reset values (rst_n = 0 at a rising edge), any state, including mid-frame:
  - state IDLE, `rr_ptr` 0, `cur_ch` 0.
  - `tx_req` 0, `tx_dat` 0, `busy` 0.
  - `ch_gnt`, `ch_done`, `ch_err` all 0; counters 0.
  - A frame in flight is abandoned; no `ch_done` is issued. The downstream sender is reset by the same `rst_n`.
- Request to launch: `ch_req` seen high in IDLE at edge E → `ch_gnt` high in cycle E+1. `tx_req` high in cycle E+2 (SEND registers it).
- Done to response: `tx_done` high at WAIT edge D → `ch_done` high in cycle D+1 → GAP for GAP_CYC cycles. The earliest next `ch_gnt` is at cycle D+GAP_CYC+2.
- `busy` rises with `ch_gnt` and falls on return to IDLE.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Configuration
- `UART_ARB_WDT_EN` defined:
  - A 32-bit WAIT-cycle counter, cleared on WAIT entry.
  - Timeout at WDT_CYC cycles → `ch_err` pulse and abandon the frame as described above.
- Not defined:
  - No counter and no timeout; WAIT persists until `tx_done`.
  - `ch_err` is constant 0.

## Test plan
- Single request: CH_NUM=4, GAP_CYC=4, `ch_req`=4'b0010 with frame 24'h33_22_11.
  - `ch_gnt`=4'b0010 one cycle later; `tx_req` pulse the next cycle with `tx_dat`=24'h332211.
  - Model `tx_done` 50 cycles later → `ch_done`=4'b0010 one cycle after, `busy` low 4 cycles after that.
- Round robin: `ch_req`=4'b1111 held, re-asserted after each grant.
  - Grant order is 0,1,2,3,0.
  - Gap between `ch_done` and the next `ch_gnt` is exactly GAP_CYC+1 cycles.
- Wrap and skip: last grant ch3, then `ch_req`=4'b0101 → ch0 granted, then ch2, then ch0.
- Spurious done: `tx_done` pulsed in IDLE and in GAP → no `ch_done`, state and `rr_ptr` unchanged.
- Reset mid-frame: assert `rst_n`=0 for one edge during WAIT.
  - All outputs return to reset values next cycle; no `ch_done`.
  - A later request on ch0 is granted normally.
- Watchdog (macro defined, WDT_CYC=100): grant ch1, never pulse `tx_done` → `ch_err`=4'b0010 after 100 WAIT cycles, then the gap, then IDLE; without the macro the block stays in WAIT, `busy`=1.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Requester and sender handshake bundle for the UART transmit arbiter.
// The arbiter connects through the slave modport, the surrounding logic through master.
interface uart_tx_arb_if #(
  parameter int CH_NUM      = 4,
  parameter int FRAME_BYTES = 3
);
  logic [CH_NUM-1:0]               ch_req;
  logic [CH_NUM*FRAME_BYTES*8-1:0] ch_dat;
  logic [CH_NUM-1:0]               ch_gnt;
  logic [CH_NUM-1:0]               ch_done;
  logic [CH_NUM-1:0]               ch_err;
  logic                            tx_req;
  logic [FRAME_BYTES*8-1:0]        tx_dat;
  logic                            tx_done;

  modport master (
    output ch_req, ch_dat, tx_done,
    input  ch_gnt, ch_done, ch_err, tx_req, tx_dat
  );

  modport slave (
    input  ch_req, ch_dat, tx_done,
    output ch_gnt, ch_done, ch_err, tx_req, tx_dat
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding fixed-length frames from CH_NUM requesters into one
// multi-byte UART sender. Define UART_ARB_WDT_EN to enable the WAIT-state watchdog.
module uart_tx_arb #(
  parameter int CH_NUM      = 4,
  parameter int FRAME_BYTES = 3,
  parameter int GAP_CYC     = 16,
  parameter int WDT_CYC     = 2000000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  uart_tx_arb_if.slave     bus,
  output logic             busy,
  output logic [2:0]       cur_ch
);

  localparam int FW = FRAME_BYTES * 8;
  localparam logic [CH_NUM-1:0] ONE_HOT = CH_NUM'(1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_GAP} state_t;

  // With no gap configured a finished frame returns straight to IDLE.
  localparam state_t ST_POST = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;

  state_t            state_reg, state_next;
  logic [2:0]        rr_ptr_reg, rr_ptr_next;
  logic [2:0]        cur_ch_reg, cur_ch_next;
  logic [FW-1:0]     tx_dat_reg, tx_dat_next;
  logic              tx_req_reg, tx_req_next;
  logic [CH_NUM-1:0] gnt_reg, gnt_next;
  logic [CH_NUM-1:0] done_reg, done_next;
  logic [15:0]       gap_cnt_reg, gap_cnt_next;

  logic              pick_found;
  logic [2:0]        pick_ch;
  logic [3:0]        scan_idx;

`ifdef UART_ARB_WDT_EN
  localparam logic [31:0] WDT_LAST = 32'(WDT_CYC - 1);
  logic [31:0]       wdt_cnt_reg, wdt_cnt_next;
  logic [CH_NUM-1:0] err_reg, err_next;
`endif

  // Search starts at rr_ptr and wraps, so the last-granted channel goes last.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = 3'd0;
    scan_idx   = 4'd0;
    for (int i = 0; i < CH_NUM; i++) begin
      scan_idx = {1'b0, rr_ptr_reg} + 4'(i);
      if (scan_idx >= 4'(CH_NUM)) begin
        scan_idx = scan_idx - 4'(CH_NUM);
      end
      if (!pick_found && (|((bus.ch_req >> scan_idx) & ONE_HOT))) begin
        pick_found = 1'b1;
        pick_ch    = scan_idx[2:0];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    cur_ch_next  = cur_ch_reg;
    tx_dat_next  = tx_dat_reg;
    tx_req_next  = 1'b0;
    gnt_next     = '0;
    done_next    = '0;
    gap_cnt_next = gap_cnt_reg;
`ifdef UART_ARB_WDT_EN
    wdt_cnt_next = wdt_cnt_reg;
    err_next     = '0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          state_next  = ST_SEND;
          tx_dat_next = FW'(bus.ch_dat >> (FW * pick_ch));
          cur_ch_next = pick_ch;
          gnt_next    = ONE_HOT << pick_ch;
          rr_ptr_next = (pick_ch == 3'(CH_NUM - 1)) ? 3'd0 : pick_ch + 3'd1;
        end
      end
      ST_SEND: begin
        tx_req_next = 1'b1;
        state_next  = ST_WAIT;
`ifdef UART_ARB_WDT_EN
        wdt_cnt_next = '0;
`endif
      end
      ST_WAIT: begin
        if (bus.tx_done) begin
          done_next    = ONE_HOT << cur_ch_reg;
          state_next   = ST_POST;
          gap_cnt_next = '0;
        end
`ifdef UART_ARB_WDT_EN
        else if (wdt_cnt_reg == WDT_LAST) begin
          err_next     = ONE_HOT << cur_ch_reg;
          state_next   = ST_POST;
          gap_cnt_next = '0;
        end else begin
          wdt_cnt_next = wdt_cnt_reg + 32'd1;
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      rr_ptr_reg  <= 3'd0;
      cur_ch_reg  <= 3'd0;
      tx_dat_reg  <= '0;
      tx_req_reg  <= 1'b0;
      gnt_reg     <= '0;
      done_reg    <= '0;
      gap_cnt_reg <= '0;
`ifdef UART_ARB_WDT_EN
      wdt_cnt_reg <= '0;
      err_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      cur_ch_reg  <= cur_ch_next;
      tx_dat_reg  <= tx_dat_next;
      tx_req_reg  <= tx_req_next;
      gnt_reg     <= gnt_next;
      done_reg    <= done_next;
      gap_cnt_reg <= gap_cnt_next;
`ifdef UART_ARB_WDT_EN
      wdt_cnt_reg <= wdt_cnt_next;
      err_reg     <= err_next;
`endif
    end
  end

  assign bus.ch_gnt  = gnt_reg;
  assign bus.ch_done = done_reg;
  assign bus.tx_req  = tx_req_reg;
  assign bus.tx_dat  = tx_dat_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign cur_ch      = cur_ch_reg;
`ifdef UART_ARB_WDT_EN
  assign bus.ch_err  = err_reg;
`else
  assign bus.ch_err  = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_tx_arb;
  localparam int CH  = 4;
  localparam int FB  = 3;
  localparam int GAP = 4;
  localparam int WDT = 100;
  localparam int FW  = FB * 8;
`ifdef UART_ARB_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       busy;
  logic [2:0] cur_ch;

  uart_tx_arb_if #(.CH_NUM(CH), .FRAME_BYTES(FB)) bus ();

  uart_tx_arb #(
    .CH_NUM(CH), .FRAME_BYTES(FB), .GAP_CYC(GAP), .WDT_CYC(WDT)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .busy   (busy),
    .cur_ch (cur_ch)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event (cycle %0d)", name, cyc);
  endtask

  // Model: edges are numbered by cyc; m_free_at is the first edge where a grant may occur.
  bit            m_active = 1'b0;
  int            m_free_at = 0;
  int            m_launch = 0;
  int            m_ptr = 0;
  int            m_cur = 0;
  logic [FW-1:0] m_dat = '0;
  logic [CH-1:0] e_gnt = '0, e_done = '0, e_err = '0;
  logic          e_txreq = 1'b0, e_busy = 1'b0;
  bit            chk_en = 1'b0;

  always @(posedge sys_clk) begin
    int k;
    cyc++;
    e_gnt   = '0;
    e_done  = '0;
    e_err   = '0;
    e_txreq = 1'b0;
    if (!rst_n) begin
      m_active  = 1'b0;
      m_free_at = 0;
      m_ptr     = 0;
      m_cur     = 0;
      m_dat     = '0;
      chk_en    = 1'b1;
    end else if (m_active) begin
      if (cyc == m_launch) begin
        e_txreq = 1'b1;
      end else if (bus.tx_done) begin
        e_done[m_cur] = 1'b1;
        m_active  = 1'b0;
        m_free_at = cyc + 1 + GAP;
      end else if (WDT_ON && (cyc == m_launch + WDT)) begin
        e_err[m_cur] = 1'b1;
        m_active  = 1'b0;
        m_free_at = cyc + 1 + GAP;
      end
    end else if (cyc >= m_free_at && bus.ch_req != '0) begin
      k = -1;
      for (int i = 0; i < CH; i++) begin
        if (k < 0 && bus.ch_req[(m_ptr + i) % CH]) k = (m_ptr + i) % CH;
      end
      e_gnt[k]  = 1'b1;
      m_cur     = k;
      m_dat     = bus.ch_dat[k*FW +: FW];
      m_ptr     = (k + 1) % CH;
      m_active  = 1'b1;
      m_launch  = cyc + 1;
    end
    e_busy = m_active || (cyc + 1 < m_free_at);
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check("m_ch_gnt",  64'(bus.ch_gnt),  64'(e_gnt));
      check("m_ch_done", 64'(bus.ch_done), 64'(e_done));
      check("m_ch_err",  64'(bus.ch_err),  64'(e_err));
      check("m_tx_req",  64'(bus.tx_req),  64'(e_txreq));
      check("m_tx_dat",  64'(bus.tx_dat),  64'(m_dat));
      check("m_busy",    64'(busy),        64'(e_busy));
      check("m_cur_ch",  64'(cur_ch),      64'(m_cur));
    end
  end

  task automatic wait_gnt(output int k, output bit ok);
    int w = 0;
    k  = -1;
    ok = 1'b0;
    while (bus.ch_gnt == '0 && w < 100) begin
      @(negedge sys_clk);
      w++;
    end
    if (bus.ch_gnt == '0) begin
      fail_now("gnt_timeout");
      return;
    end
    for (int i = 0; i < CH; i++) if (bus.ch_gnt[i]) k = i;
    ok = 1'b1;
  endtask

  // Acts as the sender: answers tx_req with tx_done after lat cycles.
  task automatic serve(input int lat, input bit drop, input bit spur_gap,
                       output int k, output int gnt_at, output int done_at);
    bit ok;
    int w = 0;
    done_at = 0;
    wait_gnt(k, ok);
    gnt_at = cyc;
    if (!ok) return;
    if (drop) bus.ch_req[k] = 1'b0;
    do begin
      @(negedge sys_clk);
      w++;
    end while (!bus.tx_req && w < 10);
    if (!bus.tx_req) begin
      fail_now("tx_req_timeout");
      return;
    end
    repeat (lat - 1) @(negedge sys_clk);
    bus.tx_done = 1'b1;
    @(negedge sys_clk);
    bus.tx_done = 1'b0;
    done_at = cyc;
    check("ch_done", 64'(bus.ch_done), 64'(1) << k);
    if (spur_gap) begin
      @(negedge sys_clk);
      bus.tx_done = 1'b1;
      @(negedge sys_clk);
      bus.tx_done = 1'b0;
    end
  endtask

  initial begin
    int k, g, d, prev_d, t0, w;
    bit ok;
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int ws_exp[3] = '{0, 2, 0};

    bus.ch_req  = '0;
    bus.tx_done = 1'b0;
    bus.ch_dat  = {24'hD0D1D2, 24'hC0C1C2, 24'h332211, 24'hA0A1A2};

    repeat (2) @(negedge sys_clk);
    check("rst_busy",   64'(busy),        64'd0);
    check("rst_tx_req", 64'(bus.tx_req),  64'd0);
    check("rst_cur_ch", 64'(cur_ch),      64'd0);
    check("rst_tx_dat", 64'(bus.tx_dat),  64'd0);
    check("rst_gnt",    64'(bus.ch_gnt),  64'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Round robin with all channels requesting continuously
    bus.ch_req = 4'b1111;
    prev_d = 0;
    for (int i = 0; i < 5; i++) begin
      serve(10, 1'b0, 1'b0, k, g, d);
      $display("rr grant %0d: ch%0d at cycle %0d", i, k, g);
      check("rr_order", 64'(k), 64'(rr_exp[i]));
      if (i > 0) check("rr_gap", 64'(g - prev_d), 64'(GAP + 1));
      prev_d = d;
    end
    bus.ch_req = '0;
    repeat (GAP + 2) @(negedge sys_clk);

    // Single request on ch1 with detailed timing
    bus.ch_req = 4'b0010;
    @(negedge sys_clk);
    check("single_gnt",  64'(bus.ch_gnt), 64'h2);
    check("single_busy", 64'(busy),       64'd1);
    bus.ch_req = '0;
    bus.ch_dat[FW +: FW] = 24'hEEEEEE;
    @(negedge sys_clk);
    check("single_tx_req", 64'(bus.tx_req), 64'd1);
    check("single_tx_dat", 64'(bus.tx_dat), 64'h332211);
    repeat (49) @(negedge sys_clk);
    check("single_dat_hold", 64'(bus.tx_dat), 64'h332211);
    bus.tx_done = 1'b1;
    @(negedge sys_clk);
    bus.tx_done = 1'b0;
    check("single_done", 64'(bus.ch_done), 64'h2);
    repeat (3) @(negedge sys_clk);
    check("single_busy_gap", 64'(busy), 64'd1);
    @(negedge sys_clk);
    check("single_busy_end", 64'(busy), 64'd0);
    $display("single frame ch1 done at cycle %0d", cyc);
    bus.ch_dat[FW +: FW] = 24'h332211;

    // ch3 alone, then wrap and skip with 0101
    bus.ch_req = 4'b1000;
    serve(5, 1'b1, 1'b0, k, g, d);
    check("ch3_grant", 64'(k), 64'd3);
    repeat (GAP + 2) @(negedge sys_clk);
    bus.ch_req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      serve(6, 1'b0, (i == 2), k, g, d);
      $display("wrap grant %0d: ch%0d at cycle %0d", i, k, g);
      check("wrap_order", 64'(k), 64'(ws_exp[i]));
    end
    bus.ch_req = '0;
    repeat (GAP + 2) @(negedge sys_clk);

    // Spurious tx_done in IDLE must not move the pointer
    for (int i = 0; i < 2; i++) begin
      bus.tx_done = 1'b1;
      @(negedge sys_clk);
      bus.tx_done = 1'b0;
      @(negedge sys_clk);
      check("spur_idle_done", 64'(bus.ch_done), 64'd0);
      check("spur_idle_busy", 64'(busy),        64'd0);
    end
    bus.ch_req = 4'b1111;
    serve(4, 1'b0, 1'b0, k, g, d);
    bus.ch_req = '0;
    check("spur_ptr_kept", 64'(k), 64'd1);
    $display("post-spurious grant ch%0d at cycle %0d", k, g);
    repeat (GAP + 2) @(negedge sys_clk);

    // Reset in the middle of a frame
    bus.ch_req = 4'b0100;
    wait_gnt(k, ok);
    bus.ch_req = '0;
    repeat (5) @(negedge sys_clk);
    rst_n = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    check("midrst_busy",   64'(busy),       64'd0);
    check("midrst_cur_ch", 64'(cur_ch),     64'd0);
    check("midrst_tx_dat", 64'(bus.tx_dat), 64'd0);
    check("midrst_tx_req", 64'(bus.tx_req), 64'd0);
    repeat (3) @(negedge sys_clk);
    bus.ch_req = 4'b1001;
    serve(5, 1'b1, 1'b0, k, g, d);
    bus.ch_req = '0;
    check("midrst_regrant", 64'(k), 64'd0);
    $display("after mid-frame reset: grant ch%0d at cycle %0d", k, g);
    repeat (GAP + 2) @(negedge sys_clk);

    // Watchdog: ch1 granted and the sender never answers
    bus.ch_req = 4'b0010;
    wait_gnt(k, ok);
    bus.ch_req = '0;
    @(negedge sys_clk);
    check("wdt_tx_req", 64'(bus.tx_req), 64'd1);
    t0 = cyc;
`ifdef UART_ARB_WDT_EN
    w = 0;
    while (bus.ch_err == '0 && w < 300) begin
      @(negedge sys_clk);
      w++;
    end
    if (bus.ch_err == '0) begin
      fail_now("wdt_err_timeout");
    end else begin
      check("wdt_latency", 64'(cyc - t0), 64'(WDT));
      check("wdt_err",     64'(bus.ch_err), 64'h2);
      repeat (GAP) @(negedge sys_clk);
      check("wdt_idle", 64'(busy), 64'd0);
    end
    $display("watchdog abort at cycle %0d", cyc);
`else
    w = 0;
    repeat (300) @(negedge sys_clk);
    check("nowdt_busy", 64'(busy),       64'd1);
    check("nowdt_err",  64'(bus.ch_err), 64'd0);
    $display("no watchdog: still waiting at cycle %0d (launched %0d)", cyc, t0);
    rst_n = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
`endif
    repeat (3) @(negedge sys_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
